wbgpio_master: RTL
==================

# wbgpio_master

Wishbone initiator that drives a 16-in/16-out single-register GPIO peripheral from a simple command port. It issues the peripheral's set/clear write format (mask in bits 31:16, value in 15:0), performs reads, and on the peripheral's change interrupt automatically re-reads the input bits into a local shadow. It sits between a small control engine (sequencer or debug bridge) and the GPIO slave on the peripheral bus.

## Interface
- AW, 30: Wishbone word-address width.
- GPIO_ADDR, 0: fixed word address of the GPIO register (AW bits).
- TIMEOUT, 1023: cycles with `o_wb_cyc` high before abort; counter width is $clog2(TIMEOUT+1).

- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous reset, active low
- i_cmd_stb  in  1  command valid
- o_cmd_busy  out  1  command not accepted this cycle
- i_cmd_op  in  2  0=READ, 1=SET, 2=CLEAR, 3=WRITE
- i_cmd_mask  in  16  bits affected
- i_cmd_val  in  16  values for WRITE
- o_rsp_stb  out  1  one-cycle response pulse, host commands only
- o_rsp_err  out  1  bus error or timeout, valid with o_rsp_stb
- o_rsp_data  out  32  read data (READ), else 0
- i_int  in  1  change interrupt from GPIO slave
- o_gpio_in  out  16  shadow of peripheral inputs
- o_in_change  out  1  one-cycle pulse when shadow changes
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone pipelined master
- o_wb_addr  out  AW  always GPIO_ADDR
- o_wb_data  out  32  write data
- o_wb_sel  out  4  always 4'hf
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each
- i_wb_data  in  32  read data

## Operation
- States: IDLE, REQ (cyc=stb=1), WAIT (cyc=1, stb=0).
- `o_cmd_busy` = (state!=IDLE) | int_pend. Accept on i_cmd_stb & !o_cmd_busy.
- Write data: SET {mask,mask}; CLEAR {mask,16'h0}; WRITE {mask, val&mask}; READ we=0, data 0.
- int_pend: set on any cycle i_int=1; cleared when an auto-read launches. In IDLE, int_pend has priority over commands.
- Auto-read: READ, no o_rsp_stb; on ack, o_gpio_in <= i_wb_data[31:16]; o_in_change pulses if value differs.
- Host READ also updates shadow (and o_in_change) and returns full 32 bits on o_rsp_data.
- REQ -> WAIT when i_wb_stall=0; ack/err sampled in REQ or WAIT completes the transaction (cyc, stb drop next edge) -> IDLE.
- Timeout: counter cleared at launch, counts each cycle cyc=1; reaching TIMEOUT ends the cycle as err (auto-read: shadow untouched, pend not re-set).
- ack and err in same cycle: err wins.
- i_int during a transaction re-sets int_pend; serviced after return to IDLE.

## Timing
- Reset (async, immediate): cyc/stb/we=0, o_wb_data=0, state IDLE, int_pend=0, o_gpio_in=0, all pulses 0, o_rsp_data=0, timeout 0. Reset mid-transaction drops cyc immediately.
- Command accepted edge N: cyc/stb high from N+1. With stall=0, stb high exactly one cycle.
- Ack sampled at edge M: cyc low, o_rsp_stb (or shadow update / o_in_change) at M+1; IDLE at M+1, next command accepted at M+1 earliest.
- Zero-stall, ack one cycle after stb: command to response = 3 cycles.
- o_wb_addr, o_wb_sel constant; o_wb_data/o_wb_we stable while stb high.

## Structure
- Package `wbgpio_master_pkg`: op encodings, state enum, write-data formation function.
- One sub-module `wb_timeout`: loadable down/up counter with expiry flag, parameter TIMEOUT.

## Test plan
- SET mask 0x0005, ack next cycle -> o_wb_data=0x00050005, we=1, o_rsp_stb at cycle 3, err=0.
- WRITE mask 0x00F0 val 0x0A5A, stall 2 cycles -> stb held 3 cycles, o_wb_data=0x00F00050.
- i_int pulse, slave returns 0x12340000 -> auto-read, o_gpio_in=0x1234, o_in_change one pulse, no o_rsp_stb; repeat same data -> no o_in_change.
- i_cmd_stb and i_int same idle cycle -> auto-read first, command accepted after, host READ returns data with o_rsp_stb.
- No ack, TIMEOUT=15 -> cyc drops after 15 cycles, o_rsp_err=1; ack+err same cycle -> err=1.
- Reset asserted while in WAIT -> cyc/stb low asynchronously, int_pend cleared, o_cmd_busy=0 after release.

Source files
------------

// File: rtl/wbgpio_master_pkg.sv
// Shared types and helpers for the Wishbone GPIO initiator: command opcodes,
// bus state encoding and the set/clear write-word formation.
package wbgpio_master_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_SET   = 2'd1,
      OP_CLEAR = 2'd2,
      OP_WRITE = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   localparam logic [3:0] WB_SEL_ALL = 4'hf;

   // The peripheral takes a write mask in [31:16] and the new bit values in [15:0].
   function automatic logic [31:0] form_wdata(input op_e op, input logic [15:0] mask,
                                              input logic [15:0] val);
      logic [31:0] word;
      word = 32'h0;
      case (op)
         OP_SET:   word = {mask, mask};
         OP_CLEAR: word = {mask, 16'h0};
         OP_WRITE: word = {mask, val & mask};
         default:  word = 32'h0;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/wb_timeout.sv
// Bus-cycle watchdog: cleared when a transaction launches, counts every cycle
// the bus cycle is open and flags the cycle on which the limit is reached.
module wb_timeout #(
   parameter int TIMEOUT = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
   localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && (count != LIMIT)) begin
         count <= count + CW'(1);
      end
   end

   // Flag on the edge that brings the count to TIMEOUT, so cyc is open exactly TIMEOUT cycles.
   assign expired = en && (count == LAST);

endmodule

// File: rtl/wbgpio_master.sv
// Wishbone initiator for a single-register 16-in/16-out GPIO peripheral:
// host set/clear/write/read commands plus interrupt-driven shadow refresh.
module wbgpio_master
   import wbgpio_master_pkg::*;
#(
   parameter int                AW        = 30,
   parameter logic [AW-1:0]     GPIO_ADDR = '0,
   parameter int                TIMEOUT   = 1023
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_cmd_stb,
   output logic          o_cmd_busy,
   input  logic [1:0]    i_cmd_op,
   input  logic [15:0]   i_cmd_mask,
   input  logic [15:0]   i_cmd_val,
   output logic          o_rsp_stb,
   output logic          o_rsp_err,
   output logic [31:0]   o_rsp_data,
   input  logic          i_int,
   output logic [15:0]   o_gpio_in,
   output logic          o_in_change,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   output logic          o_wb_we,
   output logic [AW-1:0] o_wb_addr,
   output logic [31:0]   o_wb_data,
   output logic [3:0]    o_wb_sel,
   input  logic          i_wb_stall,
   input  logic          i_wb_ack,
   input  logic          i_wb_err,
   input  logic [31:0]   i_wb_data
);

   state_e state, state_nxt;
   logic   int_pend;
   logic   pend;
   logic   auto_txn;
   logic   launch_auto, launch_cmd, launch;
   logic   done;
   logic   timeout_hit;
   logic   bus_end, bus_err;

   // An interrupt arriving this cycle already blocks a competing host command.
   assign pend    = int_pend | i_int;
   assign launch  = launch_auto | launch_cmd;
   assign bus_end = i_wb_ack | i_wb_err | timeout_hit;
   assign bus_err = i_wb_err | (timeout_hit & ~i_wb_ack);

   assign o_wb_cyc   = (state != ST_IDLE);
   assign o_wb_stb   = (state == ST_REQ);
   assign o_cmd_busy = (state != ST_IDLE) | pend;
   assign o_wb_addr  = GPIO_ADDR;
   assign o_wb_sel   = WB_SEL_ALL;

   wb_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (i_clk),
      .rst_n   (i_reset_n),
      .clear   (launch),
      .en      (o_wb_cyc),
      .expired (timeout_hit)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt   = state;
      launch_auto = 1'b0;
      launch_cmd  = 1'b0;
      done        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pend) begin
               launch_auto = 1'b1;
               state_nxt   = ST_REQ;
            end else if (i_cmd_stb) begin
               launch_cmd = 1'b1;
               state_nxt  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus_end) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end else if (!i_wb_stall) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus_end) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: the asynchronous reset clears every register here, so a reset
   // mid-transaction leaves no stale response, shadow or pending interrupt.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         int_pend    <= 1'b0;
         auto_txn    <= 1'b0;
         o_wb_we     <= 1'b0;
         o_wb_data   <= 32'h0;
         o_rsp_stb   <= 1'b0;
         o_rsp_err   <= 1'b0;
         o_rsp_data  <= 32'h0;
         o_gpio_in   <= 16'h0;
         o_in_change <= 1'b0;
      end else begin
         o_rsp_stb   <= 1'b0;
         o_in_change <= 1'b0;

         if (launch_auto) begin
            int_pend <= 1'b0;
         end else if (i_int) begin
            int_pend <= 1'b1;
         end

         if (launch) begin
            auto_txn  <= launch_auto;
            o_wb_we   <= launch_cmd && (op_e'(i_cmd_op) != OP_READ);
            o_wb_data <= launch_cmd ? form_wdata(op_e'(i_cmd_op), i_cmd_mask, i_cmd_val)
                                    : 32'h0;
         end

         if (done) begin
            if (!auto_txn) begin
               o_rsp_stb  <= 1'b1;
               o_rsp_err  <= bus_err;
               o_rsp_data <= (!bus_err && !o_wb_we) ? i_wb_data : 32'h0;
            end
            // Inputs live in the upper half of the register; failed reads leave the shadow alone.
            if (!bus_err && !o_wb_we) begin
               o_gpio_in   <= i_wb_data[31:16];
               o_in_change <= (i_wb_data[31:16] != o_gpio_in);
            end
         end
      end
   end

endmodule
